// File: rtl/panel_pattern_gen_if.sv
// Pixel-bus bundle between the pattern generator and its consumer.
// The master side drives the controls; the slave side (the generator) drives timing and pixels.
interface panel_pattern_gen_if #(
  parameter int PORTS = 4,
  parameter int CW    = 8
);
  logic                    iEN;
  logic [2:0]              iMODE;
  logic                    iMODE_LOAD;
  logic                    iSTEP;
  logic                    oHS;
  logic                    oVS;
  logic                    oDE;
  logic [PORTS*3*CW-1:0]   oPIX;
  logic [2:0]              oMODE;
  logic                    oFRAME_START;

  modport master (
    output iEN, iMODE, iMODE_LOAD, iSTEP,
    input  oHS, oVS, oDE, oPIX, oMODE, oFRAME_START
  );

  modport slave (
    input  iEN, iMODE, iMODE_LOAD, iSTEP,
    output oHS, oVS, oDE, oPIX, oMODE, oFRAME_START
  );
endinterface

// File: rtl/panel_pattern_gen.sv
// Panel timing (HS/VS/DE) and PORTS-wide test-pattern generator; the pattern
// mode only changes on frame boundaries.
module panel_pattern_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 80,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 23,
  parameter int PORTS    = 4,
  parameter int CW       = 8
) (
  input logic              iCLK,
  input logic              iRESET,
  panel_pattern_gen_if.slave bus
);
  localparam int HT  = (H_ACTIVE + H_FP + H_SYNC + H_BP) / PORTS;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = (HT > 1) ? $clog2(HT) : 1;
  localparam int VW  = (VT > 1) ? $clog2(VT) : 1;
  localparam int HDE = H_ACTIVE / PORTS;
  localparam int HS0 = (H_ACTIVE + H_FP) / PORTS;
  localparam int HS1 = (H_ACTIVE + H_FP + H_SYNC) / PORTS;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int VS1 = V_ACTIVE + V_FP + V_SYNC;
  localparam int XW0 = $clog2(HT * PORTS) + 1;
  localparam int XW1 = (XW0 > CW) ? XW0 : CW;
  localparam int XW  = (XW1 > 4) ? XW1 : 4;
  localparam int PW  = PORTS * 3 * CW;

  logic [HW-1:0] hcReg;
  logic [VW-1:0] vcReg;
  logic [2:0]    pendReg;
  logic [2:0]    modeReg;
  logic          atOrigin;
  logic [2:0]    modeNext;
  logic          deNext;
  logic          hsNext;
  logic          vsNext;
  logic          yBit3;
  logic [PW-1:0] pixNext;

  // Outputs are registered from the counter state, so the mode being latched at
  // (0,0) must already drive the pixels computed in that same cycle.
  assign atOrigin = (hcReg == '0) && (vcReg == '0);
  assign modeNext = atOrigin ? pendReg : modeReg;
  assign deNext   = (int'(hcReg) < HDE) && (int'(vcReg) < V_ACTIVE);
  assign hsNext   = (int'(hcReg) >= HS0) && (int'(hcReg) < HS1);
  assign vsNext   = (int'(vcReg) >= VS0) && (int'(vcReg) < VS1);
  assign yBit3    = ((int'(vcReg) >> 3) & 1) != 0;

  for (genvar gi = 0; gi < PORTS; gi++) begin : gPix
    logic [XW-1:0]   x;
    logic [XW+2:0]   barQ;
    logic [2:0]      bar;
    logic [2:0]      rgb;
    logic [3*CW-1:0] px;

    assign x    = XW'(hcReg) * XW'(PORTS) + XW'(gi);
    assign barQ = {x, 3'b000} / (XW+3)'(H_ACTIVE);
    assign bar  = (barQ > (XW+3)'(7)) ? 3'd7 : barQ[2:0];

    always_comb begin
      rgb = 3'b000;
      case (modeNext)
        3'd1: rgb = 3'b111;
        3'd2: rgb = 3'b100;
        3'd3: rgb = 3'b010;
        3'd4: rgb = 3'b001;
        3'd5: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          case (bar)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
          endcase
        end
        3'd7:    rgb = (x[3] ^ yBit3) ? 3'b111 : 3'b000;
        default: rgb = 3'b000;
      endcase
      if (modeNext == 3'd6) px = {3{x[CW-1:0]}};
      else                  px = {{CW{rgb[2]}}, {CW{rgb[1]}}, {CW{rgb[0]}}};
    end

    assign pixNext[gi*3*CW +: 3*CW] = px;
  end

  assign bus.oMODE = modeReg;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      hcReg            <= '0;
      vcReg            <= '0;
      pendReg          <= '0;
      modeReg          <= '0;
      bus.oHS          <= 1'b0;
      bus.oVS          <= 1'b0;
      bus.oDE          <= 1'b0;
      bus.oPIX         <= '0;
      bus.oFRAME_START <= 1'b0;
    end else begin
      if (bus.iMODE_LOAD)  pendReg <= bus.iMODE;
      else if (bus.iSTEP)  pendReg <= pendReg + 3'd1;

      if (bus.iEN) begin
        modeReg <= modeNext;
        if (hcReg == HW'(HT - 1)) begin
          hcReg <= '0;
          if (vcReg == VW'(VT - 1)) vcReg <= '0;
          else                      vcReg <= vcReg + VW'(1);
        end else begin
          hcReg <= hcReg + HW'(1);
        end
        bus.oHS          <= hsNext;
        bus.oVS          <= vsNext;
        bus.oDE          <= deNext;
        bus.oPIX         <= deNext ? pixNext : '0;
        bus.oFRAME_START <= atOrigin;
      end else begin
        // Parked at the origin so re-enabling always begins a fresh frame.
        hcReg            <= '0;
        vcReg            <= '0;
        bus.oHS          <= 1'b0;
        bus.oVS          <= 1'b0;
        bus.oDE          <= 1'b0;
        bus.oPIX         <= '0;
        bus.oFRAME_START <= 1'b0;
      end
    end
  end
endmodule
